lamp_shifter: RTL and testbench

Downstream output stage for the bound flasher. Takes the parallel lamp vector `a_lamp` and sends it MSB-first over a 3-wire serial link (`sdo`/`sclk`/`lat`) to an external chain of 74HC595-style shift registers. It ships a new frame only when the vector differs from the last frame latched. Intermediate vectors that arrive while a frame is in flight are dropped; the value present when the block returns to idle wins.

---
 rtl/lamp_shifter.sv | 107 ++++++++++
 tb/tb_lamp_shifter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_shifter.sv
// lamp_shifter: serialises the parallel lamp vector MSB-first to a chain of 74HC595-style registers.
//   clk      : system clock, all logic on its rising edge
//   rst      : synchronous active-high reset
//   lamp_in  : parallel lamp vector, MX_LP bits
//   sdo      : serial data, MSB first, changes only while sclk is low
//   sclk     : serial clock, the external register samples sdo on its rise
//   lat      : storage-latch strobe, CLK_DIV cycles after the last bit
//   busy     : high from the first SHIFT cycle to the last LATCH cycle
//   done     : one-cycle pulse in the first IDLE cycle after LATCH
module lamp_shifter #(
   parameter int MX_LP   = 16,
   parameter int CLK_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [MX_LP-1:0] lamp_in,
   output logic             sdo,
   output logic             sclk,
   output logic             lat,
   output logic             busy,
   output logic             done
);
   localparam int BW = $clog2(MX_LP);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
   state_t           state_q, state_d;
   logic [MX_LP-1:0] shift_q, shift_d, frame_q, frame_d, last_q, last_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [DW-1:0]    div_q, div_d;
   logic             phase_q, phase_d, pend_q, pend_d, div_end;
   assign div_end = div_q == DW'(CLK_DIV - 1);
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      frame_d = frame_q;
      last_d  = last_q;
      bit_d   = bit_q;
      div_d   = div_q;
      phase_d = phase_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: if (pend_q || lamp_in != last_q) begin
            shift_d = lamp_in;
            frame_d = lamp_in;
            bit_d   = BW'(MX_LP - 1);
            div_d   = '0;
            phase_d = 1'b0;
            pend_d  = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            div_d = div_end ? '0 : div_q + 1'b1;
            if (div_end) begin
               phase_d = !phase_q;
               // falling sclk edge: the current bit has been sampled
               if (phase_q) begin
                  if (bit_q == '0) state_d = LATCH;
                  else begin
                     shift_d = shift_q << 1;
                     bit_d   = bit_q - 1'b1;
                  end
               end
            end
         end
         LATCH: begin
            div_d = div_end ? '0 : div_q + 1'b1;
            if (div_end) begin
               last_d  = frame_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         frame_q <= '0;
         last_q  <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         phase_q <= 1'b0;
         pend_q  <= 1'b1;
         sdo     <= 1'b0;
         sclk    <= 1'b0;
         lat     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         frame_q <= frame_d;
         last_q  <= last_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
         sdo     <= state_d == SHIFT && shift_d[MX_LP-1];
         sclk    <= state_d == SHIFT && phase_d;
         lat     <= state_d == LATCH;
         busy    <= state_d != IDLE;
         done    <= state_q == LATCH && state_d == IDLE;
      end
   end
endmodule

// File: tb/tb_lamp_shifter.sv
// tb_lamp_shifter: directed self-checking bench for lamp_shifter (default and CLK_DIV=1/MX_LP=4 builds).
module tb_lamp_shifter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] lamp_in = '0;
   logic        sdo, sclk, lat, busy, done;
   logic [3:0]  lamp_in2 = '0;
   logic        sdo2, sclk2, lat2, busy2, done2;
   int          errs = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   lamp_shifter #(.MX_LP(16), .CLK_DIV(2)) dut (
      .clk(clk), .rst(rst), .lamp_in(lamp_in), .sdo(sdo), .sclk(sclk),
      .lat(lat), .busy(busy), .done(done));

   lamp_shifter #(.MX_LP(4), .CLK_DIV(1)) dut2 (
      .clk(clk), .rst(rst), .lamp_in(lamp_in2), .sdo(sdo2), .sclk(sclk2),
      .lat(lat2), .busy(busy2), .done(done2));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // waits (bounded) for busy, then records one frame; lamp_in may be changed at two frame cycles
   task automatic collect(input int c1, input logic [15:0] v1, input int c2, input logic [15:0] v2,
                          output logic started, output logic [15:0] bits, output int nbits,
                          output int bcyc, output int lat_first, output int lat_n,
                          output int overlap, output logic done_o);
      int   w = 0;
      int   c = 0;
      logic prev = 1'b0;
      bits = '0; nbits = 0; lat_first = -1; lat_n = 0; overlap = 0;
      while (!busy && w < 200) begin
         tick();
         w++;
      end
      started = busy;
      while (busy && c < 200) begin
         if (sclk && !prev) begin
            bits = {bits[14:0], sdo};
            nbits++;
         end
         if (lat) begin
            if (lat_first < 0) lat_first = c;
            lat_n++;
            if (sclk) overlap++;
         end
         prev = sclk;
         if (c == c1) lamp_in = v1;
         if (c == c2) lamp_in = v2;
         tick();
         c++;
      end
      bcyc = c;
      done_o = done;
   endtask

   task automatic idle_busy_count(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (busy) cnt++;
      end
   endtask

   task automatic test_reset;
      logic st, dn; logic [15:0] b; int nb, bc, lf, ln, ov, bz;
      rst = 1'b1; lamp_in = 16'h0000;
      tick(); tick();
      checks++;
      if ({sdo, sclk, lat, busy, done} !== 5'b0) begin
         errs++; $display("FAIL reset_outputs: got %b expected 00000", {sdo, sclk, lat, busy, done});
      end
      rst = 1'b0;
      collect(-1, '0, -1, '0, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (st !== 1'b1) begin errs++; $display("FAIL reset_frame_start: got %b expected 1", st); end
      checks++;
      if (b !== 16'h0000 || nb != 16) begin
         errs++; $display("FAIL reset_frame_bits: got %h/%0d expected 0000/16", b, nb);
      end
      checks++;
      if (ln != 2) begin errs++; $display("FAIL reset_lat_len: got %0d expected 2", ln); end
      checks++;
      if (dn !== 1'b1) begin errs++; $display("FAIL reset_done: got %b expected 1", dn); end
      tick();
      checks++;
      if (done !== 1'b0) begin errs++; $display("FAIL reset_done_pulse: got %b expected 0", done); end
      idle_busy_count(100, bz);
      checks++;
      if (bz != 0) begin errs++; $display("FAIL reset_no_refire: got %0d busy cycles expected 0", bz); end
   endtask

   task automatic test_single;
      logic st, dn; logic [15:0] b; int nb, bc, lf, ln, ov;
      lamp_in = 16'h8001;
      collect(-1, '0, -1, '0, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (b !== 16'h8001 || nb != 16) begin
         errs++; $display("FAIL single_bits: got %h/%0d expected 8001/16", b, nb);
      end
      checks++;
      if (bc != 66) begin errs++; $display("FAIL single_busy_len: got %0d expected 66", bc); end
      checks++;
      if (lf != 64 || ln != 2) begin
         errs++; $display("FAIL single_lat_window: got %0d+%0d expected 64+2", lf, ln);
      end
      checks++;
      if (ov != 0) begin errs++; $display("FAIL single_lat_sclk: got %0d overlaps expected 0", ov); end
      checks++;
      if (dn !== 1'b1) begin errs++; $display("FAIL single_done: got %b expected 1", dn); end
   endtask

   task automatic test_change_mid_frame;
      logic st, dn; logic [15:0] b; int nb, bc, lf, ln, ov, bz;
      lamp_in = 16'h00FF;
      collect(10, 16'h0F0F, 30, 16'hFFFF, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (b !== 16'h00FF) begin errs++; $display("FAIL mid_first_frame: got %h expected 00ff", b); end
      checks++;
      if (dn !== 1'b1) begin errs++; $display("FAIL mid_done: got %b expected 1", dn); end
      tick();
      checks++;
      if (busy !== 1'b1) begin errs++; $display("FAIL mid_back_to_back: got busy %b expected 1", busy); end
      collect(-1, '0, -1, '0, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (b !== 16'hFFFF || nb != 16) begin
         errs++; $display("FAIL mid_second_frame: got %h/%0d expected ffff/16", b, nb);
      end
      idle_busy_count(80, bz);
      checks++;
      if (bz != 0) begin errs++; $display("FAIL mid_no_third: got %0d busy cycles expected 0", bz); end
   endtask

   task automatic test_no_redundant;
      logic st, dn; logic [15:0] b; int nb, bc, lf, ln, ov, bz;
      lamp_in = 16'h1234;
      collect(5, 16'h4321, 40, 16'h1234, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (b !== 16'h1234) begin errs++; $display("FAIL redundant_frame: got %h expected 1234", b); end
      idle_busy_count(80, bz);
      checks++;
      if (bz != 0) begin errs++; $display("FAIL redundant_refire: got %0d busy cycles expected 0", bz); end
   endtask

   task automatic test_reset_mid_frame;
      logic st, dn; logic [15:0] b; int nb, bc, lf, ln, ov;
      int w = 0;
      int lc = 0;
      lamp_in = 16'hAAAA;
      while (!busy && w < 50) begin
         tick();
         w++;
      end
      checks++;
      if (busy !== 1'b1) begin errs++; $display("FAIL rstmid_start: got busy %b expected 1", busy); end
      for (int i = 0; i < 20; i++) begin
         if (lat) lc++;
         tick();
      end
      rst = 1'b1;
      tick();
      if (lat) lc++;
      checks++;
      if ({sdo, sclk, lat, busy, done} !== 5'b0) begin
         errs++; $display("FAIL rstmid_outputs: got %b expected 00000", {sdo, sclk, lat, busy, done});
      end
      rst = 1'b0;
      checks++;
      if (lc != 0) begin errs++; $display("FAIL rstmid_no_lat: got %0d lat cycles expected 0", lc); end
      collect(-1, '0, -1, '0, st, b, nb, bc, lf, ln, ov, dn);
      checks++;
      if (b !== 16'hAAAA || nb != 16 || ln != 2) begin
         errs++; $display("FAIL rstmid_resend: got %h/%0d/%0d expected aaaa/16/2", b, nb, ln);
      end
   endtask

   task automatic test_small;
      int       w = 0;
      int       sc = 0;
      int       lc = 0;
      int       terr = 0;
      logic     prev = 1'b0;
      logic [3:0] b = '0;
      lamp_in2 = 4'h9;
      while (!busy2 && w < 50) begin
         tick();
         w++;
      end
      checks++;
      if (busy2 !== 1'b1) begin errs++; $display("FAIL small_start: got busy %b expected 1", busy2); end
      while (busy2 && sc + lc < 30) begin
         if (lat2) lc++;
         else begin
            if (sclk2 !== sc[0]) terr++;
            if (sclk2 && !prev) b = {b[2:0], sdo2};
            sc++;
         end
         prev = sclk2;
         tick();
      end
      checks++;
      if (sc != 8 || lc != 1) begin
         errs++; $display("FAIL small_lengths: got shift %0d latch %0d expected 8 and 1", sc, lc);
      end
      checks++;
      if (terr != 0) begin errs++; $display("FAIL small_sclk_toggle: got %0d bad cycles expected 0", terr); end
      checks++;
      if (b !== 4'b1001) begin errs++; $display("FAIL small_bits: got %b expected 1001", b); end
      checks++;
      if (done2 !== 1'b1) begin errs++; $display("FAIL small_done: got %b expected 1", done2); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_change_mid_frame();
      test_no_redundant();
      test_reset_mid_frame();
      test_small();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
